// File: rtl/risc5_pkg.sv
// ---------------------------------------------------------------------------
// risc5_pkg
// Shared definitions for the RISC5 iterative multiply/divide unit.
//   state_e : FSM encodings (IDLE, BUSY, FIX, DONE)
//   op_e    : operation select (OP_MUL = 0, OP_DIV = 1)
//   clog2   : ceiling log2, usable in parameter defaults
// ---------------------------------------------------------------------------
package risc5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/risc5_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// risc5_muldiv_seq_if
// Request/result bundle between the execute stage and the mul/div unit.
//   enable, run, op, sgn, hold, x, y : requester -> unit
//   stall, lo, hi, divz              : unit -> requester
// Modports: master (requester side), slave (unit side).
// ---------------------------------------------------------------------------
interface risc5_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             run;
  logic             op;
  logic             sgn;
  logic             hold;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             stall;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             divz;

  modport master (
    output enable, run, op, sgn, hold, x, y,
    input  stall, lo, hi, divz
  );

  modport slave (
    input  enable, run, op, sgn, hold, x, y,
    output stall, lo, hi, divz
  );
endinterface

// File: rtl/risc5_muldiv_step.sv
// ---------------------------------------------------------------------------
// risc5_muldiv_step
// One combinational radix-2 iteration on the {hi, lo} accumulator.
//   op   in  operation select (OP_MUL shift-add, OP_DIV restoring subtract)
//   hi_i in  WIDTH+1  upper accumulator (partial product / partial remainder)
//   lo_i in  WIDTH    lower accumulator (multiplier bits / quotient bits)
//   a_i  in  WIDTH    multiplicand magnitude / divisor magnitude
//   hi_o, lo_o out    accumulator after this step
// ---------------------------------------------------------------------------
module risc5_muldiv_step
  import risc5_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Multiply consumes lo from the bottom and shifts the sum into its top.
  // Divide shifts the remainder left and keeps the subtraction only when it
  // does not borrow; the extra hi bit holds the remainder before the compare.
  always_comb begin
    sum     = hi_i + (lo_i[0] ? {1'b0, a_i} : '0);
    shifted = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, a_i};
    hi_o    = {1'b0, sum[WIDTH:1]};
    lo_o    = {sum[0], lo_i[WIDTH-1:1]};
    if (op == OP_DIV) begin
      if (diff[WIDTH+1]) begin
        hi_o = shifted;
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end else begin
        hi_o = diff[WIDTH:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/risc5_muldiv_seq.sv
// ---------------------------------------------------------------------------
// risc5_muldiv_seq
// Iterative signed/unsigned multiply and Euclidean divide for the execute stage.
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active low
//   bus  slave modport of risc5_muldiv_seq_if:
//        enable, run, op, sgn, hold, x, y in; stall, lo, hi, divz out
// Magnitudes are iterated STEPS bits per cycle; signs are applied in FIX.
// ---------------------------------------------------------------------------
module risc5_muldiv_seq
  import risc5_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1,
  parameter int CNT_W = clog2(WIDTH / STEPS)
) (
  input logic               clk,
  input logic               rst,
  risc5_muldiv_seq_if.slave bus
);

  localparam int N = WIDTH / STEPS;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic               neg_x_q, neg_x_d;
  logic               neg_y_q, neg_y_d;
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               divz_q, divz_d;

  logic               load;
  logic               ld_neg_x, ld_neg_y;
  logic [WIDTH-1:0]   ld_abs_x, ld_abs_y;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // Chain of STEPS single-bit iterations; each stage feeds the next.
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [WIDTH:0]   hi_in, hi_out;
    logic [WIDTH-1:0] lo_in, lo_out;
    if (i == 0) begin : g_first
      assign hi_in = acc_hi_q;
      assign lo_in = acc_lo_q;
    end else begin : g_next
      assign hi_in = g_step[i-1].hi_out;
      assign lo_in = g_step[i-1].lo_out;
    end
    risc5_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op   (op_q),
      .hi_i (hi_in),
      .lo_i (lo_in),
      .a_i  (a_q),
      .hi_o (hi_out),
      .lo_o (lo_out)
    );
  end

  assign bus.stall = bus.run & rst & (state_q != DONE);
  assign bus.lo    = lo_q;
  assign bus.hi    = hi_q;
  assign bus.divz  = divz_q;

  // Operand magnitudes and signs seen at the load cycle.
  always_comb begin
    ld_neg_x = bus.sgn & bus.x[WIDTH-1];
    ld_neg_y = bus.sgn & bus.y[WIDTH-1];
    ld_abs_x = ld_neg_x ? -bus.x : bus.x;
    ld_abs_y = ld_neg_y ? -bus.y : bus.y;
  end

  // Next-state logic. FIX turns the magnitude result into the signed one:
  // the product is negated on differing signs, and a negative dividend with a
  // nonzero remainder takes one more quotient step so the remainder stays
  // non-negative. A zero divisor leaves the dividend in the remainder, so hi
  // simply gets the original x back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_x_d  = neg_x_q;
    neg_y_d  = neg_y_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    a_d      = a_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    divz_d   = divz_q;
    load     = 1'b0;

    prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    if (neg_x_q ^ neg_y_q) begin
      prod = -prod;
    end
    quo = acc_lo_q;
    rem = acc_hi_q[WIDTH-1:0];
    if (neg_x_q && (rem != '0)) begin
      quo = quo + 1'b1;
      rem = a_q - rem;
    end

    if (bus.enable) begin
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            load = 1'b1;
          end
        end
        BUSY: begin
          if (!bus.run) begin
            state_d = IDLE;
          end else begin
            acc_hi_d = g_step[STEPS-1].hi_out;
            acc_lo_d = g_step[STEPS-1].lo_out;
            if (cnt_q == CNT_W'(N - 1)) begin
              state_d = FIX;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        FIX: begin
          state_d = DONE;
          if (op_q == OP_MUL) begin
            {hi_d, lo_d} = prod;
            divz_d       = 1'b0;
          end else if (a_q == '0) begin
            lo_d   = '1;
            hi_d   = neg_x_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
            divz_d = 1'b1;
          end else begin
            lo_d   = (neg_x_q ^ neg_y_q) ? -quo : quo;
            hi_d   = rem;
            divz_d = 1'b0;
          end
        end
        DONE: begin
          if (!bus.hold) begin
            if (bus.run) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        state_d  = BUSY;
        cnt_d    = '0;
        op_d     = op_e'(bus.op);
        neg_x_d  = ld_neg_x;
        neg_y_d  = ld_neg_y;
        acc_hi_d = '0;
        acc_lo_d = ld_abs_x;
        a_d      = ld_abs_y;
      end
    end
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_x_q  <= 1'b0;
      neg_y_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      a_q      <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_x_q  <= neg_x_d;
      neg_y_q  <= neg_y_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      a_q      <= a_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      divz_q   <= divz_d;
    end
  end

endmodule
